// File: rtl/brq_pkg.sv
// Shared types and constants for the branch resolve queue.
// Optional feature macro used by the top: BRQ_STATS_EN (branch/mispredict counters).
package brq_pkg;

    localparam int BRQ_DEPTH = 4;
    localparam int BRQ_PC_W  = 32;
    localparam int BRQ_GHR_W = 8;
    localparam int BRQ_PTR_W = $clog2(BRQ_DEPTH);

    // Fall-through fetch step for a not-taken branch
    localparam logic [BRQ_PC_W-1:0] BRQ_PC_INC = 32'd4;

    // One in-flight prediction as recorded at IF
    typedef struct packed {
        logic [BRQ_PC_W-1:0]  pc;
        logic                 pred;
        logic [BRQ_PC_W-1:0]  target;
        logic [BRQ_GHR_W-1:0] ghr;
    } brq_entry_t;

endpackage

// File: rtl/brq_fifo.sv
// Generic circular buffer of prediction entries with push/pop/clear.
// The occupancy counter is kept separately from the pointers so that full
// and empty are unambiguous. Clear has priority over push and pop.
module brq_fifo
    import brq_pkg::*;
#(
    parameter int  DEPTH = BRQ_DEPTH,
    parameter type T     = brq_entry_t
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output T                           o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer, occupancy and storage update; DEPTH is a power of 2 so pointers wrap naturally
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Resolution end of the global branch predictor: records IF predictions,
// checks the oldest one against the EX outcome, and produces the predictor
// update, the front-end redirect and the repaired GHR (all registered).
// Optional macro BRQ_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int PC_W  = BRQ_PC_W,
    parameter int GHR_W = BRQ_GHR_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_push_valid,
    output logic                    o_push_ready,
    input  logic [PC_W-1:0]         i_push_pc,
    input  logic                    i_push_pred,
    input  logic [PC_W-1:0]         i_push_target,
    input  logic [GHR_W-1:0]        i_push_ghr,
    input  logic                    i_resolve_valid,
    input  logic                    i_resolve_taken,
    input  logic [PC_W-1:0]         i_resolve_target,
    input  logic                    i_flush,
    output logic                    o_upd_en,
    output logic [PC_W-1:0]         o_upd_pc,
    output logic                    o_upd_outcome,
    output logic                    o_mispredict,
    output logic [PC_W-1:0]         o_redirect_pc,
    output logic [GHR_W-1:0]        o_ghr_restore,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_protocol_err
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]             o_stat_branches,
    output logic [31:0]             o_stat_mispredicts
`endif
);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             pred;
        logic [PC_W-1:0]  target;
        logic [GHR_W-1:0] ghr;
    } entry_t;

    entry_t           w_push_entry;
    entry_t           w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_resolve;
    logic             w_mis;
    logic             w_clear;
    logic [PC_W-1:0]  w_redirect_pc;
    logic [GHR_W-1:0] w_ghr_restore;

    logic             r_upd_en;
    logic [PC_W-1:0]  r_upd_pc;
    logic             r_upd_outcome;
    logic             r_mispredict;
    logic [PC_W-1:0]  r_redirect_pc;
    logic [GHR_W-1:0] r_ghr_restore;
    logic             r_protocol_err;

    assign w_push_entry = '{pc: i_push_pc, pred: i_push_pred,
                            target: i_push_target, ghr: i_push_ghr};

    // A resolve only acts on a real head; a wrong target only matters when taken
    assign w_resolve     = i_resolve_valid && !w_empty;
    assign w_mis         = (w_head.pred != i_resolve_taken) ||
                           (i_resolve_taken && (w_head.target != i_resolve_target));
    // Mispredict discards every younger (wrong-path) entry and any same-cycle push
    assign w_clear       = i_flush || (w_resolve && w_mis);
    assign w_redirect_pc = i_resolve_taken ? i_resolve_target
                                           : (w_head.pc + PC_W'(BRQ_PC_INC));
    assign w_ghr_restore = {w_head.ghr[GHR_W-2:0], i_resolve_taken};

    brq_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_push_valid),
        .i_data  (w_push_entry),
        .i_pop   (w_resolve),
        .i_clear (w_clear),
        .o_head  (w_head),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Result registers: strobes pulse for one cycle, payloads hold until the next strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_upd_en       <= 1'b0;
            r_upd_pc       <= {PC_W{1'b0}};
            r_upd_outcome  <= 1'b0;
            r_mispredict   <= 1'b0;
            r_redirect_pc  <= {PC_W{1'b0}};
            r_ghr_restore  <= {GHR_W{1'b0}};
            r_protocol_err <= 1'b0;
        end else begin
            r_upd_en       <= w_resolve;
            r_mispredict   <= w_resolve && w_mis;
            r_protocol_err <= i_resolve_valid && w_empty;
            if (w_resolve) begin
                r_upd_pc      <= w_head.pc;
                r_upd_outcome <= i_resolve_taken;
            end
            if (w_resolve && w_mis) begin
                r_redirect_pc <= w_redirect_pc;
                r_ghr_restore <= w_ghr_restore;
            end
        end
    end

    assign o_push_ready   = !w_full;
    assign o_upd_en       = r_upd_en;
    assign o_upd_pc       = r_upd_pc;
    assign o_upd_outcome  = r_upd_outcome;
    assign o_mispredict   = r_mispredict;
    assign o_redirect_pc  = r_redirect_pc;
    assign o_ghr_restore  = r_ghr_restore;
    assign o_protocol_err = r_protocol_err;

`ifdef BRQ_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // Saturating counters of the registered update and mispredict pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (r_upd_en && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (r_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign o_stat_branches    = r_stat_branches;
    assign o_stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=4, PC_W=32, GHR_W=8).
module tb_branch_resolve_queue;

    logic        clk;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic        push_pred;
    logic [31:0] push_target;
    logic [7:0]  push_ghr;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        flush;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_outcome;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [7:0]  ghr_restore;
    logic [2:0]  count;
    logic        protocol_err;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    branch_resolve_queue dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_push_valid     (push_valid),
        .o_push_ready     (push_ready),
        .i_push_pc        (push_pc),
        .i_push_pred      (push_pred),
        .i_push_target    (push_target),
        .i_push_ghr       (push_ghr),
        .i_resolve_valid  (resolve_valid),
        .i_resolve_taken  (resolve_taken),
        .i_resolve_target (resolve_target),
        .i_flush          (flush),
        .o_upd_en         (upd_en),
        .o_upd_pc         (upd_pc),
        .o_upd_outcome    (upd_outcome),
        .o_mispredict     (mispredict),
        .o_redirect_pc    (redirect_pc),
        .o_ghr_restore    (ghr_restore),
        .o_count          (count),
        .o_protocol_err   (protocol_err)
`ifdef BRQ_STATS_EN
        ,
        .o_stat_branches    (stat_branches),
        .o_stat_mispredicts (stat_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic pred,
                            input logic [31:0] tgt, input logic [7:0] ghr);
        push_valid  = 1'b1;
        push_pc     = pc;
        push_pred   = pred;
        push_target = tgt;
        push_ghr    = ghr;
    endtask

    task automatic set_resolve(input logic taken, input logic [31:0] tgt);
        resolve_valid  = 1'b1;
        resolve_taken  = taken;
        resolve_target = tgt;
    endtask

    task automatic idle();
        push_valid    = 1'b0;
        resolve_valid = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pred,
                           input logic [31:0] tgt, input logic [7:0] ghr);
        set_push(pc, pred, tgt, ghr);
        tick();
        idle();
    endtask

    task automatic do_resolve(input logic taken, input logic [31:0] tgt);
        set_resolve(taken, tgt);
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_push(32'h0000_0AAA, 1'b1, 32'h0000_0BBB, 8'hFF);
        tick();
        tick();
        idle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
        checks++; if ({upd_en, upd_outcome, mispredict, protocol_err} !== 4'b0000) begin errors++;
            $display("FAIL reset_strobes: got %b expected 0000", {upd_en, upd_outcome, mispredict, protocol_err}); end
        checks++; if ({upd_pc, redirect_pc, ghr_restore} !== 72'd0) begin errors++;
            $display("FAIL reset_payload: got %h expected 0", {upd_pc, redirect_pc, ghr_restore}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_correct_predict();
        do_push(32'h100, 1'b1, 32'h140, 8'h00);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL t1_count_push: got %0d expected 1", count); end
        do_resolve(1'b1, 32'h140);
        checks++; if (upd_en !== 1'b1) begin errors++; $display("FAIL t1_upd_en: got %b expected 1", upd_en); end
        checks++; if (upd_pc !== 32'h100) begin errors++; $display("FAIL t1_upd_pc: got %h expected 00000100", upd_pc); end
        checks++; if (upd_outcome !== 1'b1) begin errors++; $display("FAIL t1_upd_outcome: got %b expected 1", upd_outcome); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL t1_mispredict: got %b expected 0", mispredict); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL t1_count: got %0d expected 0", count); end
        tick();
        checks++; if (upd_en !== 1'b0) begin errors++; $display("FAIL t1_upd_en_pulse: got %b expected 0", upd_en); end
        checks++; if (upd_pc !== 32'h100) begin errors++; $display("FAIL t1_upd_pc_hold: got %h expected 00000100", upd_pc); end
    endtask

    task automatic test_mispredict_taken();
        do_push(32'h200, 1'b0, 32'h0, 8'hA5);
        do_resolve(1'b1, 32'h180);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL t2_mispredict: got %b expected 1", mispredict); end
        checks++; if (redirect_pc !== 32'h180) begin errors++; $display("FAIL t2_redirect: got %h expected 00000180", redirect_pc); end
        checks++; if (ghr_restore !== 8'h4B) begin errors++; $display("FAIL t2_ghr: got %h expected 4b", ghr_restore); end
        checks++; if (upd_pc !== 32'h200 || upd_outcome !== 1'b1) begin errors++;
            $display("FAIL t2_update: got pc=%h out=%b expected pc=00000200 out=1", upd_pc, upd_outcome); end
        tick();
        checks++; if (mispredict !== 1'b0 || redirect_pc !== 32'h180) begin errors++;
            $display("FAIL t2_hold: got mis=%b pc=%h expected mis=0 pc=00000180", mispredict, redirect_pc); end
    endtask

    task automatic test_mispredict_not_taken();
        do_push(32'h300, 1'b1, 32'h340, 8'h01);
        do_push(32'h400, 1'b0, 32'h0, 8'h02);
        do_push(32'h500, 1'b0, 32'h0, 8'h04);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL t3_count_fill: got %0d expected 3", count); end
        do_resolve(1'b0, 32'h0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL t3_mispredict: got %b expected 1", mispredict); end
        checks++; if (redirect_pc !== 32'h304) begin errors++; $display("FAIL t3_redirect: got %h expected 00000304", redirect_pc); end
        checks++; if (ghr_restore !== 8'h02) begin errors++; $display("FAIL t3_ghr: got %h expected 02", ghr_restore); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL t3_count_flushed: got %0d expected 0", count); end
        // Taken with the right direction but the wrong target
        do_push(32'h5F0, 1'b1, 32'h600, 8'h80);
        do_resolve(1'b1, 32'h610);
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h610 || ghr_restore !== 8'h01) begin errors++;
            $display("FAIL t3_target: got mis=%b pc=%h ghr=%h expected mis=1 pc=00000610 ghr=01", mispredict, redirect_pc, ghr_restore); end
        // Fall-through PC wraps modulo 2^32
        do_push(32'hFFFF_FFFC, 1'b1, 32'h10, 8'h00);
        do_resolve(1'b0, 32'h0);
        checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0) begin errors++;
            $display("FAIL t3_pc_wrap: got mis=%b pc=%h expected mis=1 pc=00000000", mispredict, redirect_pc); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] exp_pc;
        // Advance pointers so the next fill wraps around the buffer end
        do_push(32'h0F00, 1'b0, 32'h0, 8'h00);
        do_push(32'h0F10, 1'b0, 32'h0, 8'h00);
        do_resolve(1'b0, 32'h0);
        do_resolve(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            do_push(32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h0, 8'h00);
        end
        checks++; if (push_ready !== 1'b0 || count !== 3'd4) begin errors++;
            $display("FAIL t4_full: got ready=%b count=%0d expected ready=0 count=4", push_ready, count); end
        do_push(32'h9999, 1'b0, 32'h0, 8'h00);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL t4_drop: got %0d expected 4", count); end
        // Push alongside a correct resolve while full: no bypass, push dropped
        set_push(32'h9998, 1'b0, 32'h0, 8'h00);
        do_resolve(1'b0, 32'h0);
        checks++; if (upd_pc !== 32'h1000 || count !== 3'd3 || mispredict !== 1'b0) begin errors++;
            $display("FAIL t4_full_pushpop: got pc=%h count=%0d mis=%b expected pc=00001000 count=3 mis=0", upd_pc, count, mispredict); end
        for (int i = 1; i < 4; i++) begin
            exp_pc = 32'h1000 + 32'(i) * 32'h10;
            do_resolve(1'b0, 32'h0);
            checks++; if (upd_en !== 1'b1 || upd_pc !== exp_pc || mispredict !== 1'b0) begin errors++;
                $display("FAIL t4_order_%0d: got en=%b pc=%h mis=%b expected en=1 pc=%h mis=0", i, upd_en, upd_pc, mispredict, exp_pc); end
        end
        checks++; if (count !== 3'd0 || push_ready !== 1'b1) begin errors++;
            $display("FAIL t4_drained: got count=%0d ready=%b expected count=0 ready=1", count, push_ready); end
    endtask

    task automatic test_back_to_back();
        do_push(32'h700, 1'b0, 32'h0, 8'h00);
        set_push(32'h710, 1'b0, 32'h0, 8'h00);
        do_resolve(1'b0, 32'h0);
        checks++; if (count !== 3'd1 || upd_pc !== 32'h700) begin errors++;
            $display("FAIL b2b_correct: got count=%0d pc=%h expected count=1 pc=00000700", count, upd_pc); end
        do_resolve(1'b0, 32'h0);
        checks++; if (upd_pc !== 32'h710 || count !== 3'd0) begin errors++;
            $display("FAIL b2b_second: got pc=%h count=%0d expected pc=00000710 count=0", upd_pc, count); end
        do_push(32'h720, 1'b0, 32'h0, 8'h00);
        set_push(32'h730, 1'b0, 32'h0, 8'h00);
        do_resolve(1'b1, 32'h800);
        checks++; if (mispredict !== 1'b1 || count !== 3'd0 || redirect_pc !== 32'h800) begin errors++;
            $display("FAIL b2b_mispredict: got mis=%b count=%0d pc=%h expected mis=1 count=0 pc=00000800", mispredict, count, redirect_pc); end
    endtask

    task automatic test_protocol_flush();
        do_resolve(1'b1, 32'h0);
        checks++; if (protocol_err !== 1'b1 || upd_en !== 1'b0) begin errors++;
            $display("FAIL t5_protocol: got err=%b en=%b expected err=1 en=0", protocol_err, upd_en); end
        tick();
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL t5_protocol_pulse: got %b expected 0", protocol_err); end
        do_push(32'hA00, 1'b0, 32'h0, 8'h00);
        do_push(32'hA10, 1'b0, 32'h0, 8'h00);
        do_push(32'hA20, 1'b0, 32'h0, 8'h00);
        flush = 1'b1;
        tick();
        idle();
        checks++; if (count !== 3'd0 || upd_en !== 1'b0) begin errors++;
            $display("FAIL t5_flush: got count=%0d en=%b expected count=0 en=0", count, upd_en); end
        // Flush with a same-cycle resolve and push
        do_push(32'h880, 1'b1, 32'h900, 8'h00);
        do_push(32'h890, 1'b0, 32'h0, 8'h00);
        flush = 1'b1;
        set_push(32'hABC, 1'b0, 32'h0, 8'h00);
        do_resolve(1'b1, 32'h900);
        checks++; if (upd_en !== 1'b1 || upd_pc !== 32'h880 || mispredict !== 1'b0 || count !== 3'd0) begin errors++;
            $display("FAIL t5_flush_resolve: got en=%b pc=%h mis=%b count=%0d expected en=1 pc=00000880 mis=0 count=0", upd_en, upd_pc, mispredict, count); end
    endtask

`ifdef BRQ_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do_push(32'hC00 + 32'(i) * 32'h4, 1'b0, 32'h0, 8'h00);
            if (i < 3) do_resolve(1'b1, 32'h50);
            else       do_resolve(1'b0, 32'h0);
        end
        tick();
        checks++; if (stat_branches !== 32'd10 || stat_mispredicts !== 32'd3) begin errors++;
            $display("FAIL t6_stats: got br=%0d mis=%0d expected br=10 mis=3", stat_branches, stat_mispredicts); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin errors++;
            $display("FAIL t6_stats_rst: got br=%0d mis=%0d expected 0 0", stat_branches, stat_mispredicts); end
    endtask
`endif

    initial begin
        rst            = 1'b1;
        push_pc        = 32'd0;
        push_pred      = 1'b0;
        push_target    = 32'd0;
        push_ghr       = 8'd0;
        resolve_taken  = 1'b0;
        resolve_target = 32'd0;
        idle();
        test_reset();
        test_correct_predict();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_full_wrap();
        test_back_to_back();
        test_protocol_flush();
`ifdef BRQ_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
